// File: rtl/coef_router_pkg.sv
// -----------------------------------------------------------------------------
// coef_router_pkg
// Shared definitions for the FIR control blocks:
//   - routerState_t : control state of the coefficient router (IDLE/LOAD/DONE)
//   - IDLE_*        : values a channel drives when it is not being addressed.
//                     Idle address and data are all-zero at any width, so the
//                     users write '0 for those.
// -----------------------------------------------------------------------------
package coef_router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } routerState_t;

    // RAM strobes are active-low, so "idle" means deasserted (high).
    localparam logic IDLE_CSN = 1'b1;
    localparam logic IDLE_WRN = 1'b1;
    localparam logic IDLE_EN  = 1'b0;

endpackage

// File: rtl/coef_router_ch.sv
// -----------------------------------------------------------------------------
// coef_router_ch
// Output register for one filter channel. Every cycle it either captures the
// shared source values (iSel=1) or falls back to the idle values (iSel=0).
//
// Ports
//   iClk, iRst            : clock, asynchronous active-high reset
//   iSel                  : 1 = load source values, 0 = load idle values
//   iCsn, iWrn            : source RAM chip select / write strobe (active-low)
//   iAddr, iData          : source RAM address / write data
//   iEnMul, iEnAddAcc     : source datapath enables
//   oCsn .. oEnAddAcc     : registered channel outputs
// -----------------------------------------------------------------------------
module coef_router_ch
    import coef_router_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iSel,
    input  logic              iCsn,
    input  logic              iWrn,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [DATA_W-1:0] iData,
    input  logic              iEnMul,
    input  logic              iEnAddAcc,
    output logic              oCsn,
    output logic              oWrn,
    output logic [ADDR_W-1:0] oAddr,
    output logic [DATA_W-1:0] oData,
    output logic              oEnMul,
    output logic              oEnAddAcc
);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oCsn      <= IDLE_CSN;
            oWrn      <= IDLE_WRN;
            oAddr     <= '0;
            oData     <= '0;
            oEnMul    <= IDLE_EN;
            oEnAddAcc <= IDLE_EN;
        end else if (iSel) begin
            oCsn      <= iCsn;
            oWrn      <= iWrn;
            oAddr     <= iAddr;
            oData     <= iData;
            oEnMul    <= iEnMul;
            oEnAddAcc <= iEnAddAcc;
        end else begin
            oCsn      <= IDLE_CSN;
            oWrn      <= IDLE_WRN;
            oAddr     <= '0;
            oData     <= '0;
            oEnMul    <= IDLE_EN;
            oEnAddAcc <= IDLE_EN;
        end
    end

endmodule

// File: rtl/coef_router.sv
// -----------------------------------------------------------------------------
// coef_router
// Routes RAM control and datapath enables to NUM_CH filter channels.
//   IDLE : direct mode - the channel picked by iModuleSel (or all channels when
//          iBroadcast=1) receives the direct inputs, one cycle later.
//   LOAD : auto-load - a ready/valid coefficient stream is written to channel
//          chCnt at address adCnt, DEPTH words per channel, channels in order.
//   DONE : one cycle; the final write and oDone appear together.
//
// Ports
//   iClk, iRst                 : clock, asynchronous active-high reset
//   iModuleSel, iBroadcast     : direct-mode channel selection
//   iCsnRam, iWrnRam           : direct-mode RAM strobes (active-low)
//   iAddrRam, iWtDtRam         : direct-mode RAM address / write data
//   iEnMul, iEnAddAcc          : direct-mode datapath enables
//   iStart, iAbort             : auto-load start pulse / abort
//   iValid, iData, oReady      : auto-load coefficient stream
//   oCsnRam .. oEnAddAcc       : per-channel outputs, channel k in bit/slice k
//   oBusy, oDone               : load in progress / completion pulse
// -----------------------------------------------------------------------------
module coef_router
    import coef_router_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int ADDR_W = 4,
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 10,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic [SEL_W-1:0]         iModuleSel,
    input  logic                     iBroadcast,
    input  logic                     iCsnRam,
    input  logic                     iWrnRam,
    input  logic [ADDR_W-1:0]        iAddrRam,
    input  logic [DATA_W-1:0]        iWtDtRam,
    input  logic                     iEnMul,
    input  logic                     iEnAddAcc,
    input  logic                     iStart,
    input  logic                     iAbort,
    input  logic                     iValid,
    input  logic [DATA_W-1:0]        iData,
    output logic                     oReady,
    output logic [NUM_CH-1:0]        oCsnRam,
    output logic [NUM_CH-1:0]        oWrnRam,
    output logic [NUM_CH*ADDR_W-1:0] oAddrRam,
    output logic [NUM_CH*DATA_W-1:0] oWtDtRam,
    output logic [NUM_CH-1:0]        oEnMul,
    output logic [NUM_CH-1:0]        oEnAddAcc,
    output logic                     oBusy,
    output logic                     oDone
);

    localparam logic [ADDR_W-1:0] AD_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [SEL_W-1:0]  CH_LAST = SEL_W'(NUM_CH - 1);

    routerState_t      stateReg, stateNext;
    logic [SEL_W-1:0]  chCntReg, chCntNext;
    logic [ADDR_W-1:0] adCntReg, adCntNext;

    // A beat is written only when it is accepted and not overridden by abort.
    logic wrBeat;

    // Source values shared by every channel register; chSel decides per
    // channel whether it takes them or the idle values.
    logic              srcCsn;
    logic              srcWrn;
    logic [ADDR_W-1:0] srcAddr;
    logic [DATA_W-1:0] srcData;
    logic              srcEnMul;
    logic              srcEnAddAcc;
    logic [NUM_CH-1:0] chSel;

    // ---------------------------------------------------------------- state
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stateReg <= IDLE;
            chCntReg <= '0;
            adCntReg <= '0;
        end else begin
            stateReg <= stateNext;
            chCntReg <= chCntNext;
            adCntReg <= adCntNext;
        end
    end

    // ------------------------------------------------- next state / control
    always_comb begin
        stateNext   = stateReg;
        chCntNext   = chCntReg;
        adCntNext   = adCntReg;
        oReady      = 1'b0;
        oBusy       = 1'b0;
        oDone       = 1'b0;
        wrBeat      = 1'b0;
        srcCsn      = IDLE_CSN;
        srcWrn      = IDLE_WRN;
        srcAddr     = '0;
        srcData     = '0;
        srcEnMul    = IDLE_EN;
        srcEnAddAcc = IDLE_EN;

        unique case (stateReg)
            IDLE: begin
                srcCsn      = iCsnRam;
                srcWrn      = iWrnRam;
                srcAddr     = iAddrRam;
                srcData     = iWtDtRam;
                srcEnMul    = iEnMul;
                srcEnAddAcc = iEnAddAcc;
                if (iStart) begin
                    stateNext = LOAD;
                    chCntNext = '0;
                    adCntNext = '0;
                end
            end

            LOAD: begin
                oReady  = 1'b1;
                oBusy   = 1'b1;
                srcCsn  = 1'b0;
                srcWrn  = 1'b0;
                srcAddr = adCntReg;
                srcData = iData;
                if (iAbort) begin
                    stateNext = IDLE;
                    chCntNext = '0;
                    adCntNext = '0;
                end else if (iValid) begin
                    wrBeat = 1'b1;
                    if (adCntReg == AD_LAST) begin
                        adCntNext = '0;
                        if (chCntReg == CH_LAST) begin
                            // Last word of the last channel: the output
                            // register shows it during DONE, alongside oDone.
                            stateNext = DONE;
                            chCntNext = '0;
                        end else begin
                            chCntNext = chCntReg + 1'b1;
                        end
                    end else begin
                        adCntNext = adCntReg + 1'b1;
                    end
                end
            end

            DONE: begin
                oBusy     = 1'b1;
                oDone     = 1'b1;
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
                chCntNext = '0;
                adCntNext = '0;
            end
        endcase
    end

    // ------------------------------------------------------ channel outputs
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : gChannel
        assign chSel[gi] =
            ((stateReg == IDLE) && (iBroadcast || (iModuleSel == SEL_W'(gi)))) ||
            (wrBeat && (chCntReg == SEL_W'(gi)));

        coef_router_ch #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) uCh (
            .iClk      (iClk),
            .iRst      (iRst),
            .iSel      (chSel[gi]),
            .iCsn      (srcCsn),
            .iWrn      (srcWrn),
            .iAddr     (srcAddr),
            .iData     (srcData),
            .iEnMul    (srcEnMul),
            .iEnAddAcc (srcEnAddAcc),
            .oCsn      (oCsnRam[gi]),
            .oWrn      (oWrnRam[gi]),
            .oAddr     (oAddrRam[gi*ADDR_W +: ADDR_W]),
            .oData     (oWtDtRam[gi*DATA_W +: DATA_W]),
            .oEnMul    (oEnMul[gi]),
            .oEnAddAcc (oEnAddAcc[gi])
        );
    end

endmodule
